// File: rtl/rob_cmplt_queue_if.sv
// -----------------------------------------------------------------------------
// rob_cmplt_queue_if
//   Bundles the completion-queue signals between the execution units (master)
//   and the completion queue (slave). The ROB side (completed/cmplt_valid) is
//   carried in the same bundle because the queue drives it directly.
//
//   flush        master -> slave   drop every pending completion
//   src_tag      master -> slave   source s tag at [s*TAG_WIDTH +: TAG_WIDTH]
//   src_valid    master -> slave   per-source tag valid
//   src_ready    slave  -> master  per-source FIFO has room
//   completed    slave  -> ROB     slot k tag at [k*TAG_WIDTH +: TAG_WIDTH]
//   cmplt_valid  slave  -> ROB     per-slot valid, packed from bit 0
//   pending_ct   slave  -> master  tags held across all FIFOs
//   rr_ptr       slave  -> master  debug view of the arbitration start source
//
// Handshake: a tag on source s is transferred on a rising edge where
//   src_valid[s] && src_ready[s] (and flush is low). The master may raise
//   src_valid at any time; src_ready depends only on the FIFO fill level, never
//   on src_valid. There is no ready on the ROB side: every cmplt_valid bit is
//   consumed in the cycle it is shown.
// -----------------------------------------------------------------------------
interface rob_cmplt_queue_if #(
    parameter int TAG_WIDTH   = 5,
    parameter int NUM_SRC     = 4,
    parameter int SRC_DEPTH   = 4,
    parameter int CMPLT_WIDTH = 3
);
    localparam int PCW = $clog2(NUM_SRC * SRC_DEPTH + 1);
    localparam int SW  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic                             flush;
    logic [TAG_WIDTH*NUM_SRC-1:0]     src_tag;
    logic [NUM_SRC-1:0]               src_valid;
    logic [NUM_SRC-1:0]               src_ready;
    logic [TAG_WIDTH*CMPLT_WIDTH-1:0] completed;
    logic [CMPLT_WIDTH-1:0]           cmplt_valid;
    logic [PCW-1:0]                   pending_ct;
    logic [SW-1:0]                    rr_ptr;

    modport master (
        output flush, src_tag, src_valid,
        input  src_ready, completed, cmplt_valid, pending_ct, rr_ptr
    );

    modport slave (
        input  flush, src_tag, src_valid,
        output src_ready, completed, cmplt_valid, pending_ct, rr_ptr
    );
endinterface

// File: rtl/rob_cmplt_queue.sv
// -----------------------------------------------------------------------------
// rob_cmplt_queue
//   Completion side of the reorder buffer. Each execution unit pushes finished
//   ROB tags into its own small FIFO; every cycle a round-robin arbiter pops up
//   to CMPLT_WIDTH non-empty FIFOs (one pop per FIFO) and registers their head
//   tags onto the ROB completion slots, packed from slot 0.
//
//   clk   in  rising-edge clock
//   rst   in  asynchronous, active-low reset
//   bus   slave side of rob_cmplt_queue_if (see that file for the signal list)
// -----------------------------------------------------------------------------
module rob_cmplt_queue #(
    parameter int TAG_WIDTH   = 5,
    parameter int NUM_SRC     = 4,
    parameter int SRC_DEPTH   = 4,
    parameter int CMPLT_WIDTH = 3
) (
    input  logic              clk,
    input  logic              rst,
    rob_cmplt_queue_if.slave  bus
);
    localparam int CTW = $clog2(SRC_DEPTH + 1);
    localparam int PW  = $clog2(SRC_DEPTH);
    localparam int SW  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int PCW = $clog2(NUM_SRC * SRC_DEPTH + 1);
    localparam int KW  = $clog2(CMPLT_WIDTH + 1);

    logic [TAG_WIDTH-1:0]             mem [NUM_SRC][SRC_DEPTH];
    logic [PW-1:0]                    rd_ptr [NUM_SRC];
    logic [PW-1:0]                    wr_ptr [NUM_SRC];
    logic [CTW-1:0]                   count [NUM_SRC];
    logic [CTW-1:0]                   count_nxt [NUM_SRC];
    logic [NUM_SRC-1:0]               ready;
    logic [NUM_SRC-1:0]               push;
    logic [NUM_SRC-1:0]               pop;
    logic [SW-1:0]                    rr_ptr;
    logic [SW-1:0]                    rr_nxt;
    logic [SW-1:0]                    last_grant;
    logic                             any_grant;
    logic [SW:0]                      scan_idx;
    logic [SW:0]                      rr_inc;
    logic [KW-1:0]                    n_grant;
    logic [TAG_WIDTH*CMPLT_WIDTH-1:0] slot_tag;
    logic [CMPLT_WIDTH-1:0]           slot_valid;
    logic [TAG_WIDTH*CMPLT_WIDTH-1:0] completed_q;
    logic [CMPLT_WIDTH-1:0]           valid_q;
    logic [PCW-1:0]                   pending_q;
    logic [PCW-1:0]                   pending_nxt;

    // Ready comes from the fill level alone, so a full FIFO refuses a push even
    // when it is being popped in the same cycle (no pass-through).
    always_comb begin
        ready = '0;
        push  = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            ready[s] = (count[s] < CTW'(SRC_DEPTH));
            push[s]  = bus.src_valid[s] & ready[s] & ~bus.flush;
        end
    end

    // Round-robin scan starting at rr_ptr. The k-th non-empty source found
    // lands in slot k, which keeps cmplt_valid packed from bit 0.
    always_comb begin
        pop        = '0;
        slot_tag   = '0;
        slot_valid = '0;
        n_grant    = '0;
        last_grant = rr_ptr;
        any_grant  = 1'b0;
        scan_idx   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            scan_idx = {1'b0, rr_ptr} + (SW+1)'(i);
            if (scan_idx >= (SW+1)'(NUM_SRC)) begin
                scan_idx = scan_idx - (SW+1)'(NUM_SRC);
            end
            if (!bus.flush && (count[scan_idx[SW-1:0]] != '0) &&
                (n_grant < KW'(CMPLT_WIDTH))) begin
                pop[scan_idx[SW-1:0]] = 1'b1;
                slot_tag[n_grant*TAG_WIDTH +: TAG_WIDTH] =
                    mem[scan_idx[SW-1:0]][rd_ptr[scan_idx[SW-1:0]]];
                slot_valid[n_grant] = 1'b1;
                n_grant    = n_grant + KW'(1);
                last_grant = scan_idx[SW-1:0];
                any_grant  = 1'b1;
            end
        end
    end

    // Next arbitration start is the source after the last one granted.
    always_comb begin
        rr_inc = {1'b0, last_grant} + (SW+1)'(1);
        if (rr_inc >= (SW+1)'(NUM_SRC)) begin
            rr_inc = rr_inc - (SW+1)'(NUM_SRC);
        end
        rr_nxt = any_grant ? rr_inc[SW-1:0] : rr_ptr;
    end

    // Per-source fill levels and their total, registered together.
    always_comb begin
        pending_nxt = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            count_nxt[s] = count[s] + CTW'(push[s]) - CTW'(pop[s]);
            pending_nxt  = pending_nxt + PCW'(count_nxt[s]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < NUM_SRC; s++) begin
                count[s]  <= '0;
                rd_ptr[s] <= '0;
                wr_ptr[s] <= '0;
            end
            rr_ptr      <= '0;
            completed_q <= '0;
            valid_q     <= '0;
            pending_q   <= '0;
        end else if (bus.flush) begin
            for (int s = 0; s < NUM_SRC; s++) begin
                count[s]  <= '0;
                rd_ptr[s] <= '0;
                wr_ptr[s] <= '0;
            end
            rr_ptr      <= '0;
            completed_q <= '0;
            valid_q     <= '0;
            pending_q   <= '0;
        end else begin
            for (int s = 0; s < NUM_SRC; s++) begin
                count[s] <= count_nxt[s];
                if (push[s]) begin
                    wr_ptr[s] <= wr_ptr[s] + PW'(1);
                end
                if (pop[s]) begin
                    rd_ptr[s] <= rd_ptr[s] + PW'(1);
                end
            end
            rr_ptr      <= rr_nxt;
            completed_q <= slot_tag;
            valid_q     <= slot_valid;
            pending_q   <= pending_nxt;
        end
    end

    // Tag storage needs no reset: a slot is only read once its count covers it.
    always_ff @(posedge clk) begin
        for (int s = 0; s < NUM_SRC; s++) begin
            if (push[s]) begin
                mem[s][wr_ptr[s]] <= bus.src_tag[s*TAG_WIDTH +: TAG_WIDTH];
            end
        end
    end

    assign bus.src_ready   = ready;
    assign bus.completed   = completed_q;
    assign bus.cmplt_valid = valid_q;
    assign bus.pending_ct  = pending_q;
    assign bus.rr_ptr      = rr_ptr;

endmodule

// File: tb/tb_rob_cmplt_queue.sv
module tb_rob_cmplt_queue;
    logic clk;
    logic rst;

    rob_cmplt_queue_if bus ();

    rob_cmplt_queue dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0]  valid;
        logic [19:0] tags;
        logic        flush;
        logic [2:0]  exp_cv;
        logic [14:0] exp_cmp;
        logic [4:0]  exp_pend;
        logic [3:0]  exp_rdy;
        logic [1:0]  exp_rr;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic [3:0] v,
                                input logic [4:0] t0, input logic [4:0] t1,
                                input logic [4:0] t2, input logic [4:0] t3,
                                input logic f, input logic [2:0] cv,
                                input logic [4:0] c0, input logic [4:0] c1,
                                input logic [4:0] c2, input logic [4:0] pend,
                                input logic [3:0] rdy, input logic [1:0] rr);
        vec_t r;
        r.valid    = v;
        r.tags     = {t3, t2, t1, t0};
        r.flush    = f;
        r.exp_cv   = cv;
        r.exp_cmp  = {c2, c1, c0};
        r.exp_pend = pend;
        r.exp_rdy  = rdy;
        r.exp_rr   = rr;
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [3:0] v, input logic [19:0] tags, input logic f);
        bus.src_valid = v;
        bus.src_tag   = tags;
        bus.flush     = f;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard ----------------
    logic [4:0] exp_q [4][$];

    task automatic check_idle_outputs(input string tag);
        check({tag, " cv"},      32'(bus.cmplt_valid), 32'd0);
        check({tag, " cmp"},     32'(bus.completed),   32'd0);
        check({tag, " pending"}, 32'(bus.pending_ct),  32'd0);
        check({tag, " ready"},   32'(bus.src_ready),   32'hF);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        drive(4'b0, 20'd0, 1'b0);

        // Vector table: each row is driven for one edge, then outputs checked.
        //           valid    t0     t1     t2     t3    fl  cv      c0     c1     c2    pend  rdy   rr
        vecs[0]  = mk(4'b0010, 5'd0,  5'd5,  5'd0,  5'd0,  0, 3'b000, 5'd0,  5'd0,  5'd0,  5'd1, 4'hF, 2'd0);
        vecs[1]  = mk(4'b0000, 5'd0,  5'd0,  5'd0,  5'd0,  0, 3'b001, 5'd5,  5'd0,  5'd0,  5'd0, 4'hF, 2'd2);
        vecs[2]  = mk(4'b0000, 5'd0,  5'd0,  5'd0,  5'd0,  0, 3'b000, 5'd0,  5'd0,  5'd0,  5'd0, 4'hF, 2'd2);
        vecs[3]  = mk(4'b1000, 5'd0,  5'd0,  5'd0,  5'd7,  0, 3'b000, 5'd0,  5'd0,  5'd0,  5'd1, 4'hF, 2'd2);
        vecs[4]  = mk(4'b0000, 5'd0,  5'd0,  5'd0,  5'd0,  0, 3'b001, 5'd7,  5'd0,  5'd0,  5'd0, 4'hF, 2'd0);
        vecs[5]  = mk(4'b1111, 5'd1,  5'd2,  5'd3,  5'd4,  0, 3'b000, 5'd0,  5'd0,  5'd0,  5'd4, 4'hF, 2'd0);
        vecs[6]  = mk(4'b0000, 5'd0,  5'd0,  5'd0,  5'd0,  0, 3'b111, 5'd1,  5'd2,  5'd3,  5'd1, 4'hF, 2'd3);
        vecs[7]  = mk(4'b0000, 5'd0,  5'd0,  5'd0,  5'd0,  0, 3'b001, 5'd4,  5'd0,  5'd0,  5'd0, 4'hF, 2'd0);
        vecs[8]  = mk(4'b0000, 5'd0,  5'd0,  5'd0,  5'd0,  0, 3'b000, 5'd0,  5'd0,  5'd0,  5'd0, 4'hF, 2'd0);
        vecs[9]  = mk(4'b1101, 5'd10, 5'd0,  5'd11, 5'd12, 0, 3'b000, 5'd0,  5'd0,  5'd0,  5'd3, 4'hF, 2'd0);
        vecs[10] = mk(4'b0000, 5'd0,  5'd0,  5'd0,  5'd0,  0, 3'b111, 5'd10, 5'd11, 5'd12, 5'd0, 4'hF, 2'd0);
        vecs[11] = mk(4'b0100, 5'd0,  5'd0,  5'd13, 5'd0,  0, 3'b000, 5'd0,  5'd0,  5'd0,  5'd1, 4'hF, 2'd0);
        vecs[12] = mk(4'b0000, 5'd0,  5'd0,  5'd0,  5'd0,  0, 3'b001, 5'd13, 5'd0,  5'd0,  5'd0, 4'hF, 2'd3);
        vecs[13] = mk(4'b1011, 5'd14, 5'd15, 5'd0,  5'd16, 0, 3'b000, 5'd0,  5'd0,  5'd0,  5'd3, 4'hF, 2'd3);
        vecs[14] = mk(4'b0000, 5'd0,  5'd0,  5'd0,  5'd0,  0, 3'b111, 5'd16, 5'd14, 5'd15, 5'd0, 4'hF, 2'd2);
        vecs[15] = mk(4'b0010, 5'd0,  5'd17, 5'd0,  5'd0,  1, 3'b000, 5'd0,  5'd0,  5'd0,  5'd0, 4'hF, 2'd0);
        vecs[16] = mk(4'b0000, 5'd0,  5'd0,  5'd0,  5'd0,  0, 3'b000, 5'd0,  5'd0,  5'd0,  5'd0, 4'hF, 2'd0);

        // ---- reset state, no clock edge needed ----
        #2;
        check_idle_outputs("reset");
        check("reset rr", 32'(bus.rr_ptr), 32'd0);
        step;
        step;
        rst = 1'b1;

        // ---- table: single tag, round robin, rr wrap, idle flush ----
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].valid, vecs[i].tags, vecs[i].flush);
            step;
            check($sformatf("row%0d cv", i),      32'(bus.cmplt_valid), 32'(vecs[i].exp_cv));
            check($sformatf("row%0d cmp", i),     32'(bus.completed),   32'(vecs[i].exp_cmp));
            check($sformatf("row%0d pending", i), 32'(bus.pending_ct),  32'(vecs[i].exp_pend));
            check($sformatf("row%0d ready", i),   32'(bus.src_ready),   32'(vecs[i].exp_rdy));
            check($sformatf("row%0d rr", i),      32'(bus.rr_ptr),      32'(vecs[i].exp_rr));
        end
        drive(4'b0, 20'd0, 1'b0);

        // ---- flush with 6 tags pending while src 2 offers tag 9 ----
        for (int c = 0; c < 3; c++) begin
            drive(4'hF, {5'(23 + 4*c), 5'(22 + 4*c), 5'(21 + 4*c), 5'(20 + 4*c)}, 1'b0);
            step;
        end
        check("flush pre pending", 32'(bus.pending_ct), 32'd6);
        drive(4'b0100, {5'd0, 5'd9, 5'd0, 5'd0}, 1'b1);
        step;
        drive(4'b0, 20'd0, 1'b0);
        check_idle_outputs("flush");
        check("flush rr", 32'(bus.rr_ptr), 32'd0);
        for (int c = 0; c < 6; c++) begin
            step;
            check($sformatf("post flush cv%0d", c), 32'(bus.cmplt_valid), 32'd0);
        end

        // ---- all four sources pushing every cycle: FIFOs fill, scoreboard ----
        begin
            int         seq [4];
            logic [3:0] acc;
            logic [4:0] tg [4];
            logic [4:0] t;
            logic [2:0] cvp;
            int         pend_m;
            for (int s = 0; s < 4; s++) seq[s] = 0;
            for (int cyc = 0; cyc < 60; cyc++) begin
                for (int s = 0; s < 4; s++) tg[s] = {2'(s), 3'(seq[s])};
                drive((cyc < 44) ? 4'hF : 4'h0, {tg[3], tg[2], tg[1], tg[0]}, 1'b0);
                acc = bus.src_valid & bus.src_ready;
                step;
                cvp = bus.cmplt_valid + 3'd1;
                check("stress packed", 32'(bus.cmplt_valid & cvp), 32'd0);
                for (int k = 0; k < 3; k++) begin
                    if (bus.cmplt_valid[k]) begin
                        t = bus.completed[k*5 +: 5];
                        if (exp_q[t[4:3]].size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL stress extra: got tag %0d, required none pending", t);
                        end else begin
                            check("stress tag", 32'(t), 32'(exp_q[t[4:3]].pop_front()));
                        end
                    end
                end
                for (int s = 0; s < 4; s++) begin
                    if (acc[s]) begin
                        exp_q[s].push_back(tg[s]);
                        seq[s]++;
                    end
                end
                pend_m = 0;
                for (int s = 0; s < 4; s++) begin
                    pend_m += exp_q[s].size();
                    check($sformatf("stress ready%0d", s), 32'(bus.src_ready[s]),
                          32'(exp_q[s].size() < 4));
                end
                check("stress pending", 32'(bus.pending_ct), 32'(pend_m));
            end
            for (int s = 0; s < 4; s++) begin
                check($sformatf("stress drained%0d", s), 32'(exp_q[s].size()), 32'd0);
            end
        end

        // ---- asynchronous reset in the middle of traffic ----
        for (int c = 0; c < 6; c++) begin
            drive(4'hF, {5'd4, 5'd3, 5'd2, 5'd1}, 1'b0);
            step;
        end
        #3;
        rst = 1'b0;
        #1;
        check_idle_outputs("async rst");
        check("async rst rr", 32'(bus.rr_ptr), 32'd0);
        step;
        check_idle_outputs("rst held");
        drive(4'b0, 20'd0, 1'b0);
        rst = 1'b1;
        step;
        check_idle_outputs("rst released");

        // ---- src 0 alone, 10 tags back to back: in-order, pointers wrap ----
        for (int e = 0; e < 12; e++) begin
            if (e < 10) drive(4'b0001, {15'd0, 5'(e + 1)}, 1'b0);
            else        drive(4'b0000, 20'd0, 1'b0);
            step;
            if (e >= 1 && e <= 10) begin
                check($sformatf("wrap e%0d cv", e),  32'(bus.cmplt_valid), 32'b001);
                check($sformatf("wrap e%0d tag", e), 32'(bus.completed),   32'(e));
            end else begin
                check($sformatf("wrap e%0d cv", e),  32'(bus.cmplt_valid), 32'd0);
            end
            check($sformatf("wrap e%0d pending", e), 32'(bus.pending_ct),
                  (e <= 9) ? 32'd1 : 32'd0);
            check($sformatf("wrap e%0d ready", e), 32'(bus.src_ready), 32'hF);
        end

        // ---- final report ----
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
